memory_stage: RTL and testbench

- SEQ-datapath memory stage, directly downstream of the execute stage: consumes valE (computed address/result), valA and valP.
- Performs the Y86-64 data-memory read or write for each instruction and produces valM for writeback.
- Owns the architectural status register (Stat): AOK/HLT/ADR/INS, sticky until reset.
- Internally holds a byte-addressable, little-endian data memory that is reset-clearable.

---
 rtl/y86_pkg.sv | 31 +++
 rtl/memory_stage_data_mem.sv | 41 ++++
 rtl/memory_stage.sv | 110 +++++++++++
 tb/tb_memory_stage.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings used by fetch, execute, memory and writeback.
package y86_pkg;

    // Instruction codes (icode field of the first instruction byte)
    typedef enum logic [3:0] {
        I_HALT  = 4'h0,
        I_NOP   = 4'h1,
        I_CMOV  = 4'h2,
        I_IRMOV = 4'h3,
        I_RMMOV = 4'h4,
        I_MRMOV = 4'h5,
        I_OPQ   = 4'h6,
        I_JXX   = 4'h7,
        I_CALL  = 4'h8,
        I_RET   = 4'h9,
        I_PUSH  = 4'hA,
        I_POP   = 4'hB
    } icode_e;

    // Architectural status codes
    typedef enum logic [2:0] {
        STAT_AOK = 3'd1,
        STAT_HLT = 3'd2,
        STAT_ADR = 3'd3,
        STAT_INS = 3'd4
    } stat_e;

    // Number of bytes in one quad-word memory access
    localparam int WORD_BYTES = 8;

endpackage

// File: rtl/memory_stage_data_mem.sv
// Byte-addressable little-endian data memory: one combinational 64-bit read
// port, one synchronous 64-bit write port, cleared by async active-low reset.
module data_mem
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] rd_addr_i,
    output logic [63:0]   rd_data_o,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [63:0]   wr_data_i
);

    logic [7:0] mem_q [MEM_BYTES];

    // Assemble eight consecutive bytes, lowest address in the least significant byte
    always_comb begin
        rd_data_o = '0;
        for (int i = 0; i < WORD_BYTES; i++) begin
            rd_data_o[8*i +: 8] = mem_q[rd_addr_i + AW'(i)];
        end
    end

    // Clear everything on reset, otherwise scatter the write word into eight bytes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_BYTES; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int i = 0; i < WORD_BYTES; i++) begin
                mem_q[wr_addr_i + AW'(i)] <= wr_data_i[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/memory_stage.sv
// SEQ memory stage: decodes the access for the current icode, range-checks
// the address, drives the data memory and keeps the sticky status register.
module memory_stage
    import y86_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int AW        = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  icode,
    input  logic [63:0] valA,
    input  logic [63:0] valE,
    input  logic [63:0] valP,
    input  logic        imem_error,
    input  logic        instr_valid,
    output logic [63:0] valM,
    output logic        dmem_error,
    output logic [2:0]  stat,
    output logic        halted
);

    // Highest legal start address; the compare is done on all 64 bits so
    // addresses near 2^64 never wrap back into range.
    localparam logic [63:0] LAST_ADDR = 64'(MEM_BYTES - WORD_BYTES);

    logic        isRead;
    logic        isWrite;
    logic [63:0] accessAddr;
    logic [63:0] wrData;
    logic [63:0] rdData;
    logic        wrEn;
    stat_e       statNext;
    stat_e       stat_q;
    stat_e       stat_d;

    // Pick the access kind, address and store data for the current instruction
    always_comb begin
        isRead     = 1'b0;
        isWrite    = 1'b0;
        accessAddr = valE;
        wrData     = valA;
        case (icode)
            I_RMMOV, I_PUSH: isWrite = 1'b1;
            I_CALL: begin
                isWrite = 1'b1;
                wrData  = valP;
            end
            I_MRMOV: isRead = 1'b1;
            I_POP, I_RET: begin
                isRead     = 1'b1;
                accessAddr = valA;
            end
            default: ;
        endcase
    end

    assign dmem_error = (isRead || isWrite) && (accessAddr > LAST_ADDR);

    // Status this instruction would produce, highest-priority fault first
    always_comb begin
        statNext = STAT_AOK;
        if (imem_error) begin
            statNext = STAT_ADR;
        end else if (!instr_valid) begin
            statNext = STAT_INS;
        end else if (dmem_error) begin
            statNext = STAT_ADR;
        end else if (icode == I_HALT) begin
            statNext = STAT_HLT;
        end
    end

    // Once a fault or halt is recorded it stays until reset
    always_comb begin
        stat_d = stat_q;
        if (stat_q == STAT_AOK) begin
            stat_d = statNext;
        end
    end

    // Status register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= STAT_AOK;
        end else begin
            stat_q <= stat_d;
        end
    end

    // Memory only changes for an in-range store from a machine that stays running
    assign wrEn   = isWrite && !dmem_error && !halted && (statNext == STAT_AOK);
    assign halted = (stat_q != STAT_AOK);
    assign stat   = stat_q;
    assign valM   = (isRead && !dmem_error) ? rdData : 64'd0;

    data_mem #(
        .MEM_BYTES(MEM_BYTES),
        .AW       (AW)
    ) u_data_mem (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr_i(accessAddr[AW-1:0]),
        .rd_data_o(rdData),
        .wr_en_i  (wrEn),
        .wr_addr_i(accessAddr[AW-1:0]),
        .wr_data_i(wrData)
    );

endmodule

// File: tb/tb_memory_stage.sv
// Self-checking bench for memory_stage: directed scenarios followed by random
// instruction streams, all compared against a byte-array reference model.
module tb_memory_stage;

    localparam int MEM_BYTES = 1024;

    logic        clk;
    logic        rst_n;
    logic [3:0]  icode;
    logic [63:0] valA;
    logic [63:0] valE;
    logic [63:0] valP;
    logic        imem_error;
    logic        instr_valid;
    logic [63:0] valM;
    logic        dmem_error;
    logic [2:0]  stat;
    logic        halted;

    int vecCount  = 0;
    int missCount = 0;

    logic [7:0] refMem [MEM_BYTES];
    int         refStat;

    memory_stage #(
        .MEM_BYTES(MEM_BYTES),
        .AW       (10)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .icode      (icode),
        .valA       (valA),
        .valE       (valE),
        .valP       (valP),
        .imem_error (imem_error),
        .instr_valid(instr_valid),
        .valM       (valM),
        .dmem_error (dmem_error),
        .stat       (stat),
        .halted     (halted)
    );

    // Free-running clock, rising edges at 5, 15, 25 ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compare one observed value against the model's expectation
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        assert (observed === expected)
        else begin
            missCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model helpers: address class and the address each icode uses
    function automatic bit isWriteOp(input logic [3:0] ic);
        return (ic == 4'h4) || (ic == 4'hA) || (ic == 4'h8);
    endfunction

    function automatic bit isReadOp(input logic [3:0] ic);
        return (ic == 4'h5) || (ic == 4'hB) || (ic == 4'h9);
    endfunction

    function automatic logic [63:0] opAddr(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e);
        return ((ic == 4'hB) || (ic == 4'h9)) ? a : e;
    endfunction

    function automatic bit addrBad(input logic [63:0] addr);
        return addr > 64'(MEM_BYTES - 8);
    endfunction

    function automatic logic [63:0] modelWord(input logic [63:0] addr);
        logic [63:0] w;
        w = '0;
        for (int k = 7; k >= 0; k--) begin
            w = (w << 8) | 64'(refMem[int'(addr) + k]);
        end
        return w;
    endfunction

    // Drive one instruction, check the combinational read side, clock it, check status
    task automatic applyStimulus(input logic [3:0] ic, input logic [63:0] a, input logic [63:0] e,
                                 input logic [63:0] p, input bit iErr, input bit iValid, input string tag);
        logic [63:0] addr;
        logic [63:0] expM;
        bit          expErr;
        int          nextStat;
        icode = ic; valA = a; valE = e; valP = p;
        imem_error = iErr; instr_valid = iValid;
        addr   = opAddr(ic, a, e);
        expErr = (isReadOp(ic) || isWriteOp(ic)) && addrBad(addr);
        expM   = (isReadOp(ic) && !expErr) ? modelWord(addr) : 64'd0;
        #3;
        checkOutput({tag, ".valM"}, valM, expM);
        checkOutput({tag, ".dmem_error"}, 64'(dmem_error), 64'(expErr));
        @(posedge clk);
        if (refStat == 1) begin
            if (iErr)            nextStat = 3;
            else if (!iValid)    nextStat = 4;
            else if (expErr)     nextStat = 3;
            else if (ic == 4'h0) nextStat = 2;
            else                 nextStat = 1;
            if (nextStat == 1 && isWriteOp(ic)) begin
                for (int k = 0; k < 8; k++) begin
                    refMem[int'(addr) + k] = (ic == 4'h8) ? p[8*k +: 8] : a[8*k +: 8];
                end
            end
            refStat = nextStat;
        end
        #1;
        checkOutput({tag, ".stat"}, 64'(stat), 64'(refStat));
        checkOutput({tag, ".halted"}, 64'(halted), 64'(refStat != 1));
    endtask

    // Assert reset mid-cycle while a read of 0x10 is presented; everything clears at once
    task automatic applyReset(input string tag);
        icode = 4'h5; valE = 64'h10; valA = '0; valP = '0;
        imem_error = 1'b0; instr_valid = 1'b1;
        rst_n = 1'b0;
        for (int k = 0; k < MEM_BYTES; k++) refMem[k] = 8'h00;
        refStat = 1;
        #1;
        checkOutput({tag, ".stat"}, 64'(stat), 64'd1);
        checkOutput({tag, ".halted"}, 64'(halted), 64'd0);
        checkOutput({tag, ".valM"}, valM, 64'd0);
        icode = 4'h1;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Random 64-bit address biased toward in-range, edge and wrapping values
    function automatic logic [63:0] randAddr();
        int sel;
        sel = int'($urandom_range(0, 9));
        if (sel < 6)       return 64'($urandom_range(0, MEM_BYTES - 8));
        else if (sel < 8)  return 64'($urandom_range(MEM_BYTES - 16, MEM_BYTES + 8));
        else if (sel == 8) return 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
        else               return {$urandom, $urandom};
    endfunction

    initial begin
        rst_n = 1'b0; icode = 4'h1; valA = '0; valE = '0; valP = '0;
        imem_error = 1'b0; instr_valid = 1'b1;
        refStat = 1;
        @(posedge clk);
        #1;
        applyReset("reset0");

        // Store then reload, including an unaligned read
        applyStimulus(4'h4, 64'h1122334455667788, 64'h10, 64'h0, 0, 1, "rmmovq");
        applyStimulus(4'h5, 64'h0, 64'h10, 64'h0, 0, 1, "mrmovq10");
        applyStimulus(4'h5, 64'h0, 64'h13, 64'h0, 0, 1, "mrmovq13");
        checkOutput("unaligned.const", modelWord(64'h13), 64'h0000001122334455);

        // call at the top word, ret reads it back, then an out-of-range push
        applyStimulus(4'h8, 64'h0, 64'h3F8, 64'h40, 0, 1, "call");
        applyStimulus(4'h9, 64'h3F8, 64'h0, 64'h0, 0, 1, "ret");
        applyStimulus(4'hA, 64'hDEAD, 64'h3F9, 64'h0, 0, 1, "pushq3F9");
        applyStimulus(4'h5, 64'h0, 64'h3F8, 64'h0, 0, 1, "readHalted");

        // Wrapping address must not alias into memory
        applyReset("reset1");
        applyStimulus(4'h5, 64'h0, 64'hFFFFFFFFFFFFFFFC, 64'h0, 0, 1, "wrap");

        // Status priority
        applyReset("reset2");
        applyStimulus(4'h0, 64'h0, 64'h0, 64'h0, 1, 0, "prioImem");
        applyReset("reset3");
        applyStimulus(4'h1, 64'h0, 64'h0, 64'h0, 0, 0, "prioIns");
        applyReset("reset4");
        applyStimulus(4'h4, 64'h55, 64'h20, 64'h0, 0, 1, "preHalt");
        applyStimulus(4'h0, 64'h0, 64'h0, 64'h0, 0, 1, "halt");

        // Frozen memory while halted, then reset clears it
        applyStimulus(4'h4, 64'hAB, 64'h20, 64'h0, 0, 1, "stickyStore");
        applyStimulus(4'h5, 64'h0, 64'h20, 64'h0, 0, 1, "stickyRead");
        applyReset("reset5");
        applyStimulus(4'h5, 64'h0, 64'h20, 64'h0, 0, 1, "postResetRead");

        // Random instruction streams; restart whenever the machine stops
        for (int n = 0; n < 400; n++) begin
            logic [3:0] ic;
            int         pick;
            pick = int'($urandom_range(0, 99));
            if (pick < 2)       ic = 4'h0;
            else if (pick < 60) ic = (($urandom_range(0, 1) == 0) ? 4'h4 : 4'hA);
            else                ic = 4'($urandom_range(1, 11));
            applyStimulus(ic, (ic == 4'h9 || ic == 4'hB) ? randAddr() : {$urandom, $urandom},
                          randAddr(), {$urandom, $urandom},
                          ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) != 0), "rand");
            if (refStat != 1) applyReset("randReset");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

    // Hard time bound so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL timeout vectors=%0d", vecCount);
        $fatal(1, "[TB] timeout");
    end

endmodule
